// File: rtl/posit_req_arbiter.sv
// posit_req_arbiter: round-robin sharing of one posit_top unit among NUM_REQ
// requesters. A single-entry issue stage holds the granted command, and an
// in-order tracking FIFO records requester IDs so that in-order results can be
// steered back to their originators.
// Optional feature macro: POSIT_ARB_PERF_EN enables the issue/stall counters;
// when it is undefined the perf ports are tied to zero.
module posit_req_arbiter #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NUM_OPERANDS = 3,
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MAX_OUT      = 4,
  localparam int unsigned CMD_W       = NUM_OPERANDS * WIDTH + 8
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0][CMD_W-1:0]   req_cmd_i,
  output logic                            unit_valid_o,
  input  logic                            unit_ready_i,
  output logic [CMD_W-1:0]                unit_cmd_o,
  input  logic                            unit_out_valid_i,
  output logic                            unit_out_ready_o,
  input  logic [WIDTH-1:0]                unit_result_i,
  input  logic [4:0]                      unit_status_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  input  logic [NUM_REQ-1:0]              rsp_ready_i,
  output logic [WIDTH-1:0]                rsp_result_o,
  output logic [4:0]                      rsp_status_o,
  output logic                            err_o,
  output logic [NUM_REQ-1:0][15:0]        perf_issue_o,
  output logic [15:0]                     perf_stall_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_found;
  logic [31:0]       cand;
  logic              can_accept;
  logic              accept;

  logic [IDX_W-1:0]  fifo_q [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [IDX_W-1:0]  head;
  logic              fifo_empty;
  logic              pop;

  // Round-robin grant: first valid requester searching upward from rr_ptr+1
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid_i[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Accept when the issue slot frees this cycle and a tracking slot is free
  always_comb begin
    can_accept = ((state == ST_EMPTY) || unit_ready_i) && (count < CNT_W'(MAX_OUT));
    accept     = can_accept && grant_found;
  end

  // Only the granted requester sees ready
  always_comb begin
    req_ready_o = '0;
    if (accept) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Issue stage FSM: held command, valid flag and round-robin pointer
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_EMPTY;
      unit_valid_o <= 1'b0;
      unit_cmd_o   <= '0;
      rr_ptr       <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state        <= ST_HELD;
            unit_valid_o <= 1'b1;
            unit_cmd_o   <= req_cmd_i[grant_idx];
            rr_ptr       <= grant_idx;
          end
        end
        ST_HELD: begin
          if (accept) begin
            // Unit takes the held command while a new one is loaded
            state        <= ST_HELD;
            unit_valid_o <= 1'b1;
            unit_cmd_o   <= req_cmd_i[grant_idx];
            rr_ptr       <= grant_idx;
          end else if (unit_ready_i) begin
            state        <= ST_EMPTY;
            unit_valid_o <= 1'b0;
          end
        end
        default: begin
          state        <= ST_EMPTY;
          unit_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Tracking FIFO status and response-side handshake
  always_comb begin
    head       = fifo_q[rd_ptr];
    fifo_empty = (count == '0);
    pop        = unit_out_valid_i && !fifo_empty && rsp_ready_i[head];
  end

  // Tracking FIFO storage: requester ID of each issued command
  always_ff @(posedge clk_i) begin
    if (accept) begin
      fifo_q[wr_ptr] <= grant_idx;
    end
  end

  // Tracking FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Response steering; an untracked result is swallowed
  always_comb begin
    rsp_valid_o = '0;
    if (unit_out_valid_i && !fifo_empty) begin
      rsp_valid_o[head] = 1'b1;
    end
    unit_out_ready_o = fifo_empty ? 1'b1 : rsp_ready_i[head];
    rsp_result_o     = unit_result_i;
    rsp_status_o     = unit_status_i;
  end

  // Sticky error on a result that has no tracked command
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (unit_out_valid_i && fifo_empty) begin
      err_o <= 1'b1;
    end
  end

`ifdef POSIT_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] issue_cnt;
  logic [15:0]              stall_cnt;

  // Saturating per-requester issue and global stall counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && (grant_idx == IDX_W'(i)) && (issue_cnt[i] != 16'hFFFF)) begin
          issue_cnt[i] <= issue_cnt[i] + 16'd1;
        end
      end
      if ((|req_valid_i) && !accept && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  assign perf_issue_o = issue_cnt;
  assign perf_stall_o = stall_cnt;
`else
  assign perf_issue_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_posit_req_arbiter.sv
// Bench for posit_req_arbiter: a reference model of grant/issue/tracking with
// scoreboard queues for issued commands and requester IDs of in-flight work.
module tb_posit_req_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 2;
  localparam int MAX_OUT = 4;
  localparam int CMD_W   = 3 * WIDTH + 8;

  logic                          clk;
  logic                          rst;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ-1:0][CMD_W-1:0] req_cmd;
  logic                          unit_valid_o;
  logic                          unit_ready;
  logic [CMD_W-1:0]              unit_cmd_o;
  logic                          unit_out_valid;
  logic                          unit_out_ready_o;
  logic [WIDTH-1:0]              unit_result;
  logic [4:0]                    unit_status;
  logic [NUM_REQ-1:0]            rsp_valid_o;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [WIDTH-1:0]              rsp_result_o;
  logic [4:0]                    rsp_status_o;
  logic                          err_o;
  logic [NUM_REQ-1:0][15:0]      perf_issue_o;
  logic [15:0]                   perf_stall_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state and scoreboards
  int               m_rr;
  bit               m_held;
  int               m_stall;
  int               m_issue [NUM_REQ];
  logic [CMD_W-1:0] exp_cmd_q [$];
  int               id_q [$];

  posit_req_arbiter dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready_o),
    .req_cmd_i        (req_cmd),
    .unit_valid_o     (unit_valid_o),
    .unit_ready_i     (unit_ready),
    .unit_cmd_o       (unit_cmd_o),
    .unit_out_valid_i (unit_out_valid),
    .unit_out_ready_o (unit_out_ready_o),
    .unit_result_i    (unit_result),
    .unit_status_i    (unit_status),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready),
    .rsp_result_o     (rsp_result_o),
    .rsp_status_o     (rsp_status_o),
    .err_o            (err_o),
    .perf_issue_o     (perf_issue_o),
    .perf_stall_o     (perf_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  function automatic int predict_grant(input logic [NUM_REQ-1:0] v, input int rr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (rr + k) % NUM_REQ;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Apply one clock edge, updating the model from the currently driven inputs
  task automatic advance();
    int  g;
    bit  acc;
    bit  took;
    bit  pp;
    g    = predict_grant(req_valid, m_rr);
    acc  = (g >= 0) && (!m_held || unit_ready) && (id_q.size() < MAX_OUT);
    took = m_held && unit_ready;
    pp   = unit_out_valid && (id_q.size() > 0) && rsp_ready[id_q[0]];
    if (took) void'(exp_cmd_q.pop_front());
    if (pp) void'(id_q.pop_front());
    if (acc) begin
      exp_cmd_q.push_back(req_cmd[g]);
      id_q.push_back(g);
      m_issue[g]++;
      m_rr = g;
    end
    if ((req_valid != '0) && !acc) m_stall++;
    m_held = acc ? 1'b1 : (took ? 1'b0 : m_held);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_valid      = '0;
    req_cmd        = '0;
    unit_ready     = 1'b0;
    unit_out_valid = 1'b0;
    unit_result    = '0;
    unit_status    = '0;
    rsp_ready      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_rr    = NUM_REQ - 1;
    m_held  = 1'b0;
    m_stall = 0;
    foreach (m_issue[i]) m_issue[i] = 0;
    exp_cmd_q.delete();
    id_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++; if (unit_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_unit_valid got=%b exp=0", unit_valid_o); end
    vectors++; if (unit_cmd_o !== '0) begin miscompares++; $display("FAIL reset_unit_cmd got=%h exp=0", unit_cmd_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err_o); end
    vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid_o); end
    vectors++; if (perf_stall_o !== 16'd0) begin miscompares++; $display("FAIL reset_perf_stall got=%0d exp=0", perf_stall_o); end
    vectors++; if (perf_issue_o !== '0) begin miscompares++; $display("FAIL reset_perf_issue got=%h exp=0", perf_issue_o); end
    req_valid = 2'b11;
    #1;
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL reset_first_grant got=%b exp=01", req_ready_o); end
    req_valid = 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] exp_r;
    req_valid  = 2'b11;
    unit_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      req_cmd[0] = {$urandom(), $urandom(), $urandom(), 8'(2 * c)};
      req_cmd[1] = {$urandom(), $urandom(), $urandom(), 8'(2 * c + 1)};
      @(negedge clk);
      if (m_held) begin
        vectors++; if (unit_cmd_o !== exp_cmd_q[0]) begin miscompares++; $display("FAIL rr_unit_cmd c=%0d got=%h exp=%h", c, unit_cmd_o, exp_cmd_q[0]); end
      end
      vectors++; if (unit_valid_o !== m_held) begin miscompares++; $display("FAIL rr_unit_valid c=%0d got=%b exp=%b", c, unit_valid_o, m_held); end
      exp_r = (c < MAX_OUT) ? 2'(1 << (c % 2)) : 2'b00;
      vectors++; if (req_ready_o !== exp_r) begin miscompares++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, req_ready_o, exp_r); end
      advance();
    end
  endtask

  task automatic test_full_fifo();
    logic [NUM_REQ-1:0] exp_v;
    int n;
    req_valid      = 2'b01;
    req_cmd[0]     = {$urandom(), $urandom(), $urandom(), 8'hF0};
    unit_out_valid = 1'b1;
    unit_result    = 32'h0000_1111;
    unit_status    = 5'h03;
    rsp_ready      = 2'b11;
    @(negedge clk);
    vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL full_ready_during_pop got=%b exp=00", req_ready_o); end
    exp_v = 2'(1 << id_q[0]);
    vectors++; if (rsp_valid_o !== exp_v) begin miscompares++; $display("FAIL full_rsp_valid got=%b exp=%b", rsp_valid_o, exp_v); end
    vectors++; if (rsp_result_o !== 32'h0000_1111) begin miscompares++; $display("FAIL full_rsp_result got=%h exp=00001111", rsp_result_o); end
    vectors++; if (rsp_status_o !== 5'h03) begin miscompares++; $display("FAIL full_rsp_status got=%h exp=03", rsp_status_o); end
    advance();
    unit_out_valid = 1'b0;
    @(negedge clk);
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL full_slot_reuse got=%b exp=01", req_ready_o); end
    advance();
    req_valid      = 2'b00;
    unit_out_valid = 1'b1;
    n = 0;
    while (id_q.size() > 0 && n < 12) begin
      unit_result = $urandom();
      unit_status = 5'(n);
      @(negedge clk);
      exp_v = 2'(1 << id_q[0]);
      vectors++; if (rsp_valid_o !== exp_v) begin miscompares++; $display("FAIL drain_rsp_valid n=%0d got=%b exp=%b", n, rsp_valid_o, exp_v); end
      vectors++; if (rsp_result_o !== unit_result) begin miscompares++; $display("FAIL drain_rsp_result n=%0d got=%h exp=%h", n, rsp_result_o, unit_result); end
      if (m_held) begin
        vectors++; if (unit_cmd_o !== exp_cmd_q[0]) begin miscompares++; $display("FAIL drain_unit_cmd n=%0d got=%h exp=%h", n, unit_cmd_o, exp_cmd_q[0]); end
      end
      advance();
      n++;
    end
    unit_out_valid = 1'b0;
    vectors++; if (id_q.size() != 0) begin miscompares++; $display("FAIL drain_budget left=%0d exp=0", id_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [CMD_W-1:0] bp_cmd;
    bp_cmd     = {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 8'h5A};
    unit_ready = 1'b0;
    req_valid  = 2'b01;
    req_cmd[0] = bp_cmd;
    @(negedge clk);
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL bp_first_accept got=%b exp=01", req_ready_o); end
    advance();
    req_cmd[0] = ~bp_cmd;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++; if (req_ready_o !== 2'b00) begin miscompares++; $display("FAIL bp_ready c=%0d got=%b exp=00", c, req_ready_o); end
      vectors++; if (unit_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_unit_valid c=%0d got=%b exp=1", c, unit_valid_o); end
      vectors++; if (unit_cmd_o !== bp_cmd) begin miscompares++; $display("FAIL bp_unit_cmd c=%0d got=%h exp=%h", c, unit_cmd_o, bp_cmd); end
      advance();
    end
`ifdef POSIT_ARB_PERF_EN
    vectors++; if (perf_stall_o !== 16'd5) begin miscompares++; $display("FAIL bp_perf_stall got=%0d exp=5", perf_stall_o); end
    vectors++; if (perf_issue_o[0] !== 16'(m_issue[0])) begin miscompares++; $display("FAIL bp_perf_issue0 got=%0d exp=%0d", perf_issue_o[0], m_issue[0]); end
`else
    vectors++; if (perf_stall_o !== 16'd0) begin miscompares++; $display("FAIL bp_perf_tied got=%0d exp=0", perf_stall_o); end
`endif
    req_valid  = 2'b00;
    unit_ready = 1'b1;
    @(negedge clk);
    vectors++; if (unit_cmd_o !== exp_cmd_q[0]) begin miscompares++; $display("FAIL bp_release_cmd got=%h exp=%h", unit_cmd_o, exp_cmd_q[0]); end
    advance();
    @(negedge clk);
    vectors++; if (unit_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_release_valid got=%b exp=0", unit_valid_o); end
    unit_out_valid = 1'b1;
    unit_result    = 32'h0000_5555;
    rsp_ready      = 2'b01;
    #1;
    vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL bp_rsp_valid got=%b exp=01", rsp_valid_o); end
    advance();
    unit_out_valid = 1'b0;
  endtask

  task automatic test_routing();
    logic [CMD_W-1:0] add_cmd;
    logic [CMD_W-1:0] mul_cmd;
    add_cmd = {32'h4B31_C72A, 32'h48E0_0000, 32'h0000_0000, 4'h0, 1'b0, 3'b000};
    mul_cmd = {32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 4'h2, 1'b0, 3'b000};
    unit_ready = 1'b1;
    req_valid  = 2'b10;
    req_cmd[1] = add_cmd;
    @(negedge clk);
    vectors++; if (req_ready_o !== 2'b10) begin miscompares++; $display("FAIL route_grant1 got=%b exp=10", req_ready_o); end
    advance();
    req_valid  = 2'b01;
    req_cmd[0] = mul_cmd;
    @(negedge clk);
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL route_grant0 got=%b exp=01", req_ready_o); end
    vectors++; if (unit_cmd_o !== add_cmd) begin miscompares++; $display("FAIL route_add_cmd got=%h exp=%h", unit_cmd_o, add_cmd); end
    advance();
    req_valid = 2'b00;
    @(negedge clk);
    vectors++; if (unit_cmd_o !== mul_cmd) begin miscompares++; $display("FAIL route_mul_cmd got=%h exp=%h", unit_cmd_o, mul_cmd); end
    advance();
    unit_out_valid = 1'b1;
    rsp_ready      = 2'b11;
    unit_result    = 32'h0000_AAAA;
    @(negedge clk);
    vectors++; if (rsp_valid_o !== 2'b10) begin miscompares++; $display("FAIL route_rsp1_valid got=%b exp=10", rsp_valid_o); end
    vectors++; if (rsp_result_o !== 32'h0000_AAAA) begin miscompares++; $display("FAIL route_rsp1_result got=%h exp=0000aaaa", rsp_result_o); end
    advance();
    unit_result = 32'h0000_BBBB;
    @(negedge clk);
    vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL route_rsp0_valid got=%b exp=01", rsp_valid_o); end
    vectors++; if (rsp_result_o !== 32'h0000_BBBB) begin miscompares++; $display("FAIL route_rsp0_result got=%h exp=0000bbbb", rsp_result_o); end
    advance();
    unit_out_valid = 1'b0;
  endtask

  task automatic test_response_stall();
    unit_ready = 1'b1;
    req_valid  = 2'b01;
    req_cmd[0] = {$urandom(), $urandom(), $urandom(), 8'h77};
    @(negedge clk);
    vectors++; if (req_ready_o !== 2'b01) begin miscompares++; $display("FAIL stall_issue got=%b exp=01", req_ready_o); end
    advance();
    req_valid = 2'b00;
    advance();
    unit_out_valid = 1'b1;
    unit_result    = 32'h0000_CCCC;
    rsp_ready      = 2'b10;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (unit_out_ready_o !== 1'b0) begin miscompares++; $display("FAIL stall_out_ready c=%0d got=%b exp=0", c, unit_out_ready_o); end
      vectors++; if (rsp_valid_o !== 2'b01) begin miscompares++; $display("FAIL stall_rsp_valid c=%0d got=%b exp=01", c, rsp_valid_o); end
      advance();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    vectors++; if (unit_out_ready_o !== 1'b1) begin miscompares++; $display("FAIL stall_release got=%b exp=1", unit_out_ready_o); end
    advance();
    unit_out_valid = 1'b0;
  endtask

  task automatic test_spurious();
    unit_out_valid = 1'b1;
    rsp_ready      = 2'b00;
    unit_result    = 32'h0000_DEAD;
    @(negedge clk);
    vectors++; if (rsp_valid_o !== 2'b00) begin miscompares++; $display("FAIL spur_rsp_valid got=%b exp=00", rsp_valid_o); end
    vectors++; if (unit_out_ready_o !== 1'b1) begin miscompares++; $display("FAIL spur_out_ready got=%b exp=1", unit_out_ready_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL spur_err_early got=%b exp=0", err_o); end
    advance();
    unit_out_valid = 1'b0;
    @(negedge clk);
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL spur_err_set got=%b exp=1", err_o); end
    repeat (3) advance();
    @(negedge clk);
    vectors++; if (err_o !== 1'b1) begin miscompares++; $display("FAIL spur_err_sticky got=%b exp=1", err_o); end
    advance();
    do_reset();
    @(negedge clk);
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL spur_err_cleared got=%b exp=0", err_o); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full_fifo();
    test_reset();
    test_backpressure();
    test_routing();
    test_response_stall();
    test_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
